ro_multi_result_packer: RTL and testbench

- Multi-channel successor to the single-sensor result path in the AFU.
- Drains NUM_CH first-word-fall-through sample FIFOs (one per ring-oscillator sensor bank) in strict round-robin order.
- Zero-extends each SAMPLE_WIDTH sample into a RESULT_WIDTH slot and packs slots into CL_DATA_WIDTH cache lines.
- Presents each full line to the DMA write channel with backpressure. Double-buffered so that assembly never stalls on a single write wait.

---
 rtl/ro_pack_pkg.sv | 31 +++
 rtl/ro_line_assembler.sv | 53 +++++
 rtl/ro_multi_result_packer.sv | 141 ++++++++++++++
 tb/tb_ro_multi_result_packer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_pack_pkg.sv
// Shared constants and types for the ring-oscillator multi-channel result packer.
package ro_pack_pkg;

  localparam int CL_DATA_WIDTH_DEF = 512;
  localparam int RESULT_WIDTH_DEF  = 32;
  localparam int SAMPLE_WIDTH_DEF  = 20;
  localparam int NUM_CH_DEF        = 4;
  localparam int COUNT_WIDTH_DEF   = 32;

  localparam int RPC = CL_DATA_WIDTH_DEF / RESULT_WIDTH_DEF;

  // slot_count runs 0..RPC inclusive, so it needs one value beyond the last slot
  function automatic int slot_idx_w(input int rpc);
    return $clog2(rpc + 1);
  endfunction

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SLOT_W = slot_idx_w(RPC);
  localparam int CH_W   = ch_idx_w(NUM_CH_DEF);

  typedef logic [CL_DATA_WIDTH_DEF-1:0] line_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/ro_line_assembler.sv
// Slot buffer that collects RESULT_WIDTH slots into a line and hands full lines
// to a single output register feeding the DMA write channel.
module ro_line_assembler
  import ro_pack_pkg::*;
#(
  parameter int CL_DATA_WIDTH = CL_DATA_WIDTH_DEF,
  parameter int RESULT_WIDTH  = RESULT_WIDTH_DEF,
  localparam int RPC_L   = CL_DATA_WIDTH / RESULT_WIDTH,
  localparam int SLOT_WL = slot_idx_w(RPC_L)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pop,
  input  logic [RESULT_WIDTH-1:0]  slot_data,
  input  logic                     wr_en,
  output logic                     slot_full,
  output logic                     out_valid,
  output logic [CL_DATA_WIDTH-1:0] line_out,
  output logic [SLOT_WL-1:0]       slot_count
);

  logic [RPC_L-1:0][RESULT_WIDTH-1:0] asm_buf;
  logic                               handoff;
  logic [SLOT_WL-1:0]                 wr_slot;

  assign slot_full = (slot_count == SLOT_WL'(RPC_L));
  assign handoff   = slot_full && (!out_valid || wr_en);
  // a pop coinciding with a hand-off starts the next line at slot 0
  assign wr_slot   = handoff ? '0 : slot_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_buf    <= '0;
      slot_count <= '0;
      out_valid  <= 1'b0;
      line_out   <= '0;
    end else begin
      if (handoff) begin
        line_out  <= asm_buf;
        out_valid <= 1'b1;
      end else if (wr_en) begin
        out_valid <= 1'b0;
      end
      for (int s = 0; s < RPC_L; s++)
        if (pop && wr_slot == SLOT_WL'(s)) asm_buf[s] <= slot_data;
      if (handoff)
        slot_count <= pop ? SLOT_WL'(1) : '0;
      else if (pop)
        slot_count <= slot_count + SLOT_WL'(1);
    end
  end

endmodule

// File: rtl/ro_multi_result_packer.sv
// Round-robin drain of NUM_CH FWFT sample FIFOs into cache lines for the DMA write channel.
// Optional macro RO_PACK_CHANNEL_TAG_EN stores the channel index in the top bits of each slot.
module ro_multi_result_packer
  import ro_pack_pkg::*;
#(
  parameter int CL_DATA_WIDTH = CL_DATA_WIDTH_DEF,
  parameter int RESULT_WIDTH  = RESULT_WIDTH_DEF,
  parameter int SAMPLE_WIDTH  = SAMPLE_WIDTH_DEF,
  parameter int NUM_CH        = NUM_CH_DEF,
  parameter int COUNT_WIDTH   = COUNT_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           go,
  input  logic [COUNT_WIDTH-1:0]         num_lines,
  input  logic [NUM_CH-1:0]              ch_empty,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] ch_rd_data,
  output logic [NUM_CH-1:0]              ch_rd_en,
  input  logic                           wr_full,
  output logic                           wr_en,
  output logic [CL_DATA_WIDTH-1:0]       wr_data,
  output logic                           busy,
  output logic                           done,
  output logic [COUNT_WIDTH-1:0]         lines_written
);

  localparam int RPC_L   = CL_DATA_WIDTH / RESULT_WIDTH;
  localparam int SLOT_WL = slot_idx_w(RPC_L);
  localparam int CH_WL   = ch_idx_w(NUM_CH);
  localparam int TAG_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;
  localparam int SL_W    = COUNT_WIDTH + SLOT_WL;

  if (CL_DATA_WIDTH % RESULT_WIDTH != 0) begin : g_chk_div
    $error("RESULT_WIDTH must divide CL_DATA_WIDTH");
  end
  if (SAMPLE_WIDTH > RESULT_WIDTH) begin : g_chk_sw
    $error("SAMPLE_WIDTH must not exceed RESULT_WIDTH");
  end

  state_t                               state;
  logic [CH_WL-1:0]                     ptr;
  logic [SL_W-1:0]                      samples_left;
  logic [COUNT_WIDTH-1:0]               num_lines_q;
  logic [NUM_CH-1:0][SAMPLE_WIDTH-1:0]  ch_vec;
  logic [RESULT_WIDTH-1:0]              tag_word;
  logic [RESULT_WIDTH-1:0]              slot_data;
  logic                                 pop;
  logic                                 slot_full;
  logic                                 out_valid;
  logic [SLOT_WL-1:0]                   slot_count;

  assign ch_vec = ch_rd_data;

`ifdef RO_PACK_CHANNEL_TAG_EN
  if (TAG_W > 0) begin : g_tag
    if (SAMPLE_WIDTH + TAG_W > RESULT_WIDTH) begin : g_chk_tag
      $error("SAMPLE_WIDTH + channel tag does not fit in RESULT_WIDTH");
    end
    assign tag_word = {ptr, {(RESULT_WIDTH-TAG_W){1'b0}}};
  end else begin : g_notag
    assign tag_word = '0;
  end
`else
  assign tag_word = '0;
`endif

  assign slot_data = RESULT_WIDTH'(ch_vec[ptr]) | tag_word;
  assign wr_en     = out_valid && !wr_full;
  // stop popping only when the buffer is full and the output register cannot take it
  assign pop = (state == ST_RUN) && !ch_empty[ptr] && (samples_left != '0) &&
               !(slot_full && out_valid && !wr_en);

  always_comb begin
    ch_rd_en = '0;
    for (int c = 0; c < NUM_CH; c++)
      ch_rd_en[c] = pop && (ptr == CH_WL'(c));
  end

  ro_line_assembler #(
    .CL_DATA_WIDTH (CL_DATA_WIDTH),
    .RESULT_WIDTH  (RESULT_WIDTH)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .pop        (pop),
    .slot_data  (slot_data),
    .wr_en      (wr_en),
    .slot_full  (slot_full),
    .out_valid  (out_valid),
    .line_out   (wr_data),
    .slot_count (slot_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      samples_left  <= '0;
      num_lines_q   <= '0;
      lines_written <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_en) lines_written <= lines_written + COUNT_WIDTH'(1);
      case (state)
        ST_IDLE: begin
          if (go) begin
            if (num_lines != '0) begin
              num_lines_q   <= num_lines;
              lines_written <= '0;
              ptr           <= '0;
              samples_left  <= SL_W'(num_lines) * SL_W'(RPC_L);
              busy          <= 1'b1;
              state         <= ST_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (pop) begin
            ptr          <= (ptr == CH_WL'(NUM_CH-1)) ? '0 : ptr + CH_WL'(1);
            samples_left <= samples_left - SL_W'(1);
          end
          // all samples taken and the final line has left the slot buffer
          if (samples_left == '0 && slot_count == '0) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (lines_written == num_lines_q) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_multi_result_packer.sv
// Directed bench for ro_multi_result_packer: queue-backed FWFT FIFOs plus a line-level reference model.
module tb_ro_multi_result_packer;

  localparam int NCH = 4;
  localparam int SW  = 20;
  localparam int RW  = 32;
  localparam int CLW = 512;
  localparam int CW  = 32;
  localparam int RPC = CLW / RW;

`ifdef RO_PACK_CHANNEL_TAG_EN
  localparam logic [31:0] TAG1 = 32'h4000_0000;
  localparam logic [31:0] TAG3 = 32'hC000_0000;
`else
  localparam logic [31:0] TAG1 = 32'h0;
  localparam logic [31:0] TAG3 = 32'h0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                go = 1'b0;
  logic [CW-1:0]       num_lines = '0;
  logic [NCH-1:0]      ch_empty = '1;
  logic [NCH*SW-1:0]   ch_rd_data = '0;
  logic [NCH-1:0]      ch_rd_en;
  logic                wr_full = 1'b0;
  logic                wr_en;
  logic [CLW-1:0]      wr_data;
  logic                busy;
  logic                done;
  logic [CW-1:0]       lines_written;

  ro_multi_result_packer #(
    .CL_DATA_WIDTH (CLW), .RESULT_WIDTH (RW), .SAMPLE_WIDTH (SW),
    .NUM_CH (NCH), .COUNT_WIDTH (CW)
  ) dut (
    .clk (clk), .rst (rst), .go (go), .num_lines (num_lines),
    .ch_empty (ch_empty), .ch_rd_data (ch_rd_data), .ch_rd_en (ch_rd_en),
    .wr_full (wr_full), .wr_en (wr_en), .wr_data (wr_data),
    .busy (busy), .done (done), .lines_written (lines_written)
  );

  always #5 clk = ~clk;

  typedef logic [SW-1:0] smp_t;
  smp_t           q [NCH][$];
  logic [NCH-1:0] hold = '0;
  logic [NCH-1:0] pend = '0;
  logic [CLW-1:0] exp_lines [$];
  logic [CLW-1:0] got_lines [$];
  int exp_ptr = 0, pop_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [CLW-1:0] act, input logic [CLW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] slot_val(input int c, input smp_t s);
    logic [31:0] v;
    v = {12'b0, s};
`ifdef RO_PACK_CHANNEL_TAG_EN
    v[31:30] = c[1:0];
`endif
    return v;
  endfunction

  task automatic refresh();
    for (int c = 0; c < NCH; c++) begin
      ch_empty[c] = hold[c] || (q[c].size() == 0);
      ch_rd_data[c*SW +: SW] = (q[c].size() != 0) ? q[c][0] : '0;
    end
  endtask

  task automatic preload(input logic ch3_ones);
    for (int c = 0; c < NCH; c++) begin
      q[c].delete();
      for (int i = 0; i < 64; i++)
        q[c].push_back((ch3_ones && c == 3) ? smp_t'(20'hFFFFF) : smp_t'(c*'h1000 + i));
    end
    refresh();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expected lines follow directly from the rule: global sample g comes from
  // channel g%NCH, taking that channel's (g/NCH)-th queued entry.
  task automatic start(input int n);
    logic [CLW-1:0] line;
    tick();
    go = 1'b1;
    num_lines = CW'(n);
    exp_ptr = 0;
    pop_cnt = 0;
    for (int k = 0; k < n; k++) begin
      line = '0;
      for (int s = 0; s < RPC; s++) begin
        int g, c, i;
        g = k*RPC + s; c = g % NCH; i = g / NCH;
        if (i < q[c].size()) line[s*RW +: RW] = slot_val(c, q[c][i]);
      end
      exp_lines.push_back(line);
    end
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < limit && done_cnt == d0; i++) tick();
    chk("done_seen", 512'(done_cnt > d0), 512'(1));
  endtask

  // FIFO side: apply pops that the DUT committed at this edge
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NCH; c++)
      if (pend[c] && q[c].size() != 0) void'(q[c].pop_front());
    pend = '0;
    refresh();
  end

  // Compare process: read order and every written line against the model
  always @(negedge clk) begin
    if (!rst) begin
      if (ch_rd_en != '0) begin
        chk("rd_order", 512'(ch_rd_en), 512'(NCH'(1) << exp_ptr));
        chk("rd_nonempty", 512'(ch_empty & ch_rd_en), 512'(0));
        exp_ptr = (exp_ptr + 1) % NCH;
        pop_cnt++;
        pend = pend | ch_rd_en;
      end
      if (wr_en) begin
        if (exp_lines.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_write: got %0h expected none", wr_data);
        end else begin
          chk("line", wr_data, exp_lines.pop_front());
        end
        got_lines.push_back(wr_data);
        wr_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CLW-1:0] ln, snap;
    int w0, d0, bad;

    // reset values
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_wr_en", 512'(wr_en), 512'(0));
    chk("rst_rd_en", 512'(ch_rd_en), 512'(0));
    chk("rst_lw", 512'(lines_written), 512'(0));
    chk("rst_wr_data", wr_data, '0);

    // basic two-line run
    preload(1'b0);
    start(2);
    chk("busy_run", 512'(busy), 512'(1));
    wait_done(300);
    chk("t1_lw", 512'(lines_written), 512'(2));
    chk("t1_busy", 512'(busy), 512'(0));
    chk("t1_wr_cnt", 512'(wr_cnt), 512'(2));
    chk("t1_done_cnt", 512'(done_cnt), 512'(1));
    ln = got_lines[0];
    chk("t1_slot0", 512'(ln[0*RW +: RW]), 512'(32'h0000_0000));
    chk("t1_slot1", 512'(ln[1*RW +: RW]), 512'(32'h0000_1000 | TAG1));
    chk("t1_slot4", 512'(ln[4*RW +: RW]), 512'(32'h0000_0001));

    // channel 2 stalls mid-line
    preload(1'b0);
    hold[2] = 1'b1;
    refresh();
    start(1);
    for (int i = 0; i < 100 && pop_cnt < 2; i++) tick();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ch_rd_en != '0) bad++;
    end
    chk("stall_rd_en", 512'(bad), 512'(0));
    chk("stall_pops", 512'(pop_cnt), 512'(2));
    hold[2] = 1'b0;
    refresh();
    wait_done(300);
    chk("stall_lw", 512'(lines_written), 512'(1));

    // DMA backpressure
    preload(1'b0);
    wr_full = 1'b1;
    w0 = wr_cnt;
    start(3);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i == 60) snap = wr_data;
    end
    chk("bp_pops", 512'(pop_cnt), 512'(32));
    chk("bp_rd_en", 512'(ch_rd_en), 512'(0));
    chk("bp_no_wr", 512'(wr_cnt - w0), 512'(0));
    chk("bp_stable", wr_data, snap);
    chk("bp_head", wr_data, exp_lines[0]);
    wr_full = 1'b0;
    wait_done(300);
    chk("bp_lw", 512'(lines_written), 512'(3));
    chk("bp_wr_cnt", 512'(wr_cnt - w0), 512'(3));

    // zero-length run
    w0 = wr_cnt;
    tick();
    go = 1'b1;
    num_lines = '0;
    tick();
    go = 1'b0;
    chk("zero_done", 512'(done), 512'(1));
    chk("zero_busy", 512'(busy), 512'(0));
    tick();
    chk("zero_done_low", 512'(done), 512'(0));
    chk("zero_no_wr", 512'(wr_cnt - w0), 512'(0));

    // go while busy is ignored
    preload(1'b0);
    wr_full = 1'b1;
    d0 = done_cnt;
    start(1);
    repeat (5) tick();
    go = 1'b1;
    num_lines = CW'(5);
    tick();
    go = 1'b0;
    tick();
    chk("gobusy_busy", 512'(busy), 512'(1));
    wr_full = 1'b0;
    wait_done(300);
    repeat (10) tick();
    chk("gobusy_lw", 512'(lines_written), 512'(1));
    chk("gobusy_pops", 512'(pop_cnt), 512'(16));
    chk("gobusy_done_cnt", 512'(done_cnt - d0), 512'(1));
    chk("gobusy_idle", 512'(busy), 512'(0));

    // reset after 7 samples of line 1
    preload(1'b0);
    w0 = wr_cnt;
    start(2);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (pop_cnt >= 23) break;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("mid_pops", 512'(pop_cnt), 512'(23));
    chk("mid_wr_cnt", 512'(wr_cnt - w0), 512'(1));
    chk("mid_rd_en", 512'(ch_rd_en), 512'(0));
    chk("mid_wr_en", 512'(wr_en), 512'(0));
    chk("mid_wr_data", wr_data, '0);
    chk("mid_busy", 512'(busy), 512'(0));
    chk("mid_lw", 512'(lines_written), 512'(0));
    exp_lines.delete();
    d0 = done_cnt;
    repeat (3) tick();
    chk("mid_no_done", 512'(done_cnt - d0), 512'(0));
    rst = 1'b0;
    start(1);
    wait_done(300);
    ln = got_lines[got_lines.size()-1];
    chk("post_slot0", 512'(ln[0*RW +: RW]), 512'(32'h0000_0006));
    chk("post_slot3", 512'(ln[3*RW +: RW]), 512'(32'h0000_3005 | TAG3));
    chk("post_lw", 512'(lines_written), 512'(1));

    // zero-extension / channel tag of a full-scale sample
    preload(1'b1);
    start(1);
    wait_done(300);
    ln = got_lines[got_lines.size()-1];
    chk("tag_slot3", 512'(ln[3*RW +: RW]), 512'(32'h000F_FFFF | TAG3));
    chk("tag_slot7", 512'(ln[7*RW +: RW]), 512'(32'h000F_FFFF | TAG3));
    chk("exp_empty", 512'(exp_lines.size()), 512'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
